// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment constants, BCD decoder and scan FSM state type
//
// Contents:
//   SEG_0..SEG_9, SEG_BLANK : segment patterns {a,b,c,d,e,f,g,dp}, active-high
//   bcd_to_seg()            : nibble -> pattern, non-decimal nibbles go dark
//   scan_state_t            : BLANK / SHOW states of the digit slot FSM
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'b1111_1100;
  localparam logic [7:0] SEG_1     = 8'b0110_0000;
  localparam logic [7:0] SEG_2     = 8'b1101_1010;
  localparam logic [7:0] SEG_3     = 8'b1111_0010;
  localparam logic [7:0] SEG_4     = 8'b0110_0110;
  localparam logic [7:0] SEG_5     = 8'b1011_0110;
  localparam logic [7:0] SEG_6     = 8'b1011_1110;
  localparam logic [7:0] SEG_7     = 8'b1110_0000;
  localparam logic [7:0] SEG_8     = 8'b1111_1110;
  localparam logic [7:0] SEG_9     = 8'b1111_0110;
  localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    logic [7:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - display value update handshake (req/ack with BCD payload)
//
// Signals:
//   upd_req   requester -> controller  request, held with stable data until upd_ack
//   upd_data  requester -> controller  4*N_DIG bits of BCD, nibble i = digit i
//   upd_ack   controller -> requester  one-cycle pulse, upd_data captured
// Modports: master = requester side, slave = scan controller side.
interface seg_scan_ctrl_if #(
  parameter int N_DIG = 2
);

  logic                 upd_req;
  logic [4*N_DIG-1:0]   upd_data;
  logic                 upd_ack;

  modport master (
    output upd_req,
    output upd_data,
    input  upd_ack
  );

  modport slave (
    input  upd_req,
    input  upd_data,
    output upd_ack
  );

endinterface

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational nibble to segment pattern with suppress override
//
// Ports:
//   nibble    in  4  BCD value of the digit being shown
//   suppress  in  1  force a dark pattern (leading-zero blanking)
//   seg       out 8  segment pattern {a,b,c,d,e,f,g,dp}
module seg_decode (
  input  logic [3:0] nibble,
  input  logic       suppress,
  output logic [7:0] seg
);
  import seg_pkg::*;

  always_comb begin
    seg = SEG_BLANK;
    if (!suppress) begin
      seg = bcd_to_seg(nibble);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with double-buffered updates
//
// Ports:
//   clk         in   1      system clock
//   res         in   1      asynchronous active-high reset
//   upd         slave       update handshake (upd_req / upd_data / upd_ack)
//   digit_seg   out  8      segment pattern of the lit digit, 0 while blank
//   digit_con   out  N_DIG  one-hot digit enable, 0 while blank
//   frame_tick  out  1      pulse at the start of every frame after the first
//
// The cnt/idx/state registers describe the scan position that the NEXT clock
// edge will present on the outputs; every output is a register loaded from
// that position. Cycle n after reset therefore shows position n, with reset
// itself holding position 0 ready.
module seg_scan_ctrl #(
  parameter int N_DIG     = 2,
  parameter int SCAN_DIV  = 1024,
  parameter int BLANK_CYC = 16,
  parameter int LZ_BLANK  = 1
) (
  input  logic                clk,
  input  logic                res,
  seg_scan_ctrl_if.slave      upd,
  output logic [7:0]          digit_seg,
  output logic [N_DIG-1:0]    digit_con,
  output logic                frame_tick
);
  import seg_pkg::*;

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int ACT_W = 4 * N_DIG;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIG - 1);
  // With no blank interval every slot starts directly in SHOW.
  localparam scan_state_t SLOT_START = (BLANK_CYC > 0) ? BLANK : SHOW;

  scan_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ACT_W-1:0]   act_q, act_d;
  logic               first_q;

  logic [7:0]         seg_d;
  logic [N_DIG-1:0]   con_d;
  logic               tick_d;
  logic               ack_d;
  logic               ack_q;

  logic               frame_start;
  logic               capture;
  logic [3:0]         sel_nib;
  logic               sel_sup;
  logic               zero_run;
  logic [7:0]         dec_seg;

  assign upd.upd_ack = ack_q;

  seg_decode u_decode (
    .nibble   (sel_nib),
    .suppress (sel_sup),
    .seg      (dec_seg)
  );

  // Next-position and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    act_d    = act_q;
    seg_d    = SEG_BLANK;
    con_d    = '0;
    tick_d   = 1'b0;
    ack_d    = 1'b0;
    sel_nib  = 4'd0;
    sel_sup  = 1'b0;
    zero_run = 1'b1;

    // Position 0 of any frame except the very first one after reset is a
    // frame boundary; the request sampled on this edge swaps the buffer.
    frame_start = (cnt_q == '0) && (idx_q == '0) && !first_q;
    capture     = frame_start && upd.upd_req;

    if (capture) begin
      act_d = upd.upd_data;
    end

    // Walk from the most significant digit down so zero_run tells, for each
    // digit, whether it and everything above it is zero. Decode uses the
    // post-capture buffer so the new value is visible from the first SHOW
    // cycle even when there is no blank interval.
    for (int i = N_DIG - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_d[4*i +: 4] == 4'd0);
      if (idx_q == IDX_W'(i)) begin
        sel_nib = act_d[4*i +: 4];
        sel_sup = (LZ_BLANK != 0) && (i != 0) && zero_run;
      end
    end

    if (state_q == SHOW) begin
      seg_d = dec_seg;
      for (int i = 0; i < N_DIG; i++) begin
        con_d[i] = (idx_q == IDX_W'(i));
      end
    end

    tick_d = frame_start;
    ack_d  = capture;

    // Advance the scan position.
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      state_d = SLOT_START;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if ((state_q == BLANK) && (cnt_q == BLANK_LAST)) begin
        state_d = SHOW;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= SLOT_START;
      cnt_q      <= '0;
      idx_q      <= '0;
      act_q      <= '0;
      first_q    <= 1'b1;
      digit_seg  <= SEG_BLANK;
      digit_con  <= '0;
      frame_tick <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      first_q    <= 1'b0;
      digit_seg  <= seg_d;
      digit_con  <= con_d;
      frame_tick <= tick_d;
      ack_q      <= ack_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int SD  = 1024;
  localparam int BC  = 16;
  localparam int ND  = 2;
  localparam int F   = ND * SD;
  localparam int SDC = 4;
  localparam int NDC = 3;
  localparam int FC  = NDC * SDC;

  localparam logic [7:0] PAT [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                      8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res, res_c;
  logic        req, req_c;
  logic [7:0]  data;
  logic [11:0] data_c;
  logic [7:0]  seg_a, seg_b, seg_c;
  logic [1:0]  con_a, con_b;
  logic [2:0]  con_c;
  logic        tick_a, tick_b, tick_c;

  seg_scan_ctrl_if #(.N_DIG(ND))  if_a ();
  seg_scan_ctrl_if #(.N_DIG(ND))  if_b ();
  seg_scan_ctrl_if #(.N_DIG(NDC)) if_c ();

  assign if_a.upd_req  = req;
  assign if_a.upd_data = data;
  assign if_b.upd_req  = req;
  assign if_b.upd_data = data;
  assign if_c.upd_req  = req_c;
  assign if_c.upd_data = data_c;

  seg_scan_ctrl #(.N_DIG(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1)) dut_a (
    .clk(clk), .res(res), .upd(if_a), .digit_seg(seg_a), .digit_con(con_a), .frame_tick(tick_a));
  seg_scan_ctrl #(.N_DIG(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(0)) dut_b (
    .clk(clk), .res(res), .upd(if_b), .digit_seg(seg_b), .digit_con(con_b), .frame_tick(tick_b));
  seg_scan_ctrl #(.N_DIG(NDC), .SCAN_DIV(SDC), .BLANK_CYC(0), .LZ_BLANK(1)) dut_c (
    .clk(clk), .res(res_c), .upd(if_c), .digit_seg(seg_c), .digit_con(con_c), .frame_tick(tick_c));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0d got %0h want %0h", name, tag, got, exp);
    end
  endtask

  // Pattern a digit should show given the whole displayed value.
  function automatic logic [7:0] model_seg(input logic [31:0] act, input int i, input bit lz);
    logic [31:0] hi;
    int nib;
    hi  = act >> (4 * i);
    nib = int'(hi[3:0]);
    if (lz && i > 0 && hi == 32'd0) return 8'h00;
    if (nib > 9) return 8'h00;
    return PAT[nib];
  endfunction

  // Reference model for dut_a / dut_b, checked every cycle.
  bit          mon_en = 1'b0;
  int          n = 0;
  logic [31:0] act_m = '0;
  logic        prev_req = 1'b0;
  logic [7:0]  prev_data = '0;
  int          m_pos, m_i;
  logic        m_tick, m_ack;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      m_tick = 1'b0;
      m_ack  = 1'b0;
      if (n > 0 && n % F == 0) begin
        m_tick = 1'b1;
        m_ack  = prev_req;
        if (prev_req) act_m = {24'd0, prev_data};
      end
      m_pos = n % F;
      m_i   = m_pos / SD;
      if (m_pos % SD < BC) begin
        chk("a_con", n, 32'(con_a), 32'd0);
        chk("a_seg", n, 32'(seg_a), 32'd0);
        chk("b_con", n, 32'(con_b), 32'd0);
        chk("b_seg", n, 32'(seg_b), 32'd0);
      end else begin
        chk("a_con", n, 32'(con_a), 32'd1 << m_i);
        chk("a_seg", n, 32'(seg_a), 32'(model_seg(act_m, m_i, 1'b1)));
        chk("b_con", n, 32'(con_b), 32'd1 << m_i);
        chk("b_seg", n, 32'(seg_b), 32'(model_seg(act_m, m_i, 1'b0)));
      end
      chk("a_tick", n, 32'(tick_a), 32'(m_tick));
      chk("a_ack", n, 32'(if_a.upd_ack), 32'(m_ack));
      chk("b_tick", n, 32'(tick_b), 32'(m_tick));
      chk("b_ack", n, 32'(if_b.upd_ack), 32'(m_ack));
      prev_req  = req;
      prev_data = data;
      n++;
    end
  end

  task automatic release_ab();
    @(negedge clk);
    #1;
    res       = 1'b0;
    n         = 0;
    act_m     = '0;
    prev_req  = 1'b0;
    prev_data = '0;
    mon_en    = 1'b1;
  endtask

  // Return once cycle c has been displayed (its negedge sample is done).
  task automatic goto(input int c);
    int guard;
    guard = 0;
    while (n < c + 1 && guard < 20000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (n != c + 1) begin
      errors++;
      $display("FAIL goto target %0d at %0d", c, n);
    end
  endtask

  task automatic wait_ack(output int cyc);
    cyc = -1;
    for (int k = 0; k < F + 4; k++) begin
      @(negedge clk);
      #1;
      if (if_a.upd_ack === 1'b1) begin
        cyc = n - 1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic [7:0] a0, a1, b0, b1;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [1:0] con;
    logic [7:0] seg;
  } spot_t;

  vec_t  vecs [6];
  spot_t spots [8];

  int s, ac, ac2, t, r;
  bit req_done;
  logic [31:0] act_c;
  logic        prev_rc;
  logic [11:0] prev_dc;
  bit          et, ea;
  int          ci;

  initial begin
    res = 1'b1; res_c = 1'b1; req = 1'b0; data = '0; req_c = 1'b0; data_c = '0;

    vecs[0] = '{8'h05, 8'hB6, 8'h00, 8'hB6, 8'hFC};
    vecs[1] = '{8'hAF, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{8'h00, 8'hFC, 8'h00, 8'hFC, 8'hFC};
    vecs[3] = '{8'h90, 8'hFC, 8'hF6, 8'hFC, 8'hF6};
    vecs[4] = '{8'h38, 8'hFE, 8'hF2, 8'hFE, 8'hF2};
    vecs[5] = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'hFC};

    spots[0] = '{0,    2'b00, 8'h00};
    spots[1] = '{15,   2'b00, 8'h00};
    spots[2] = '{16,   2'b01, 8'hFC};
    spots[3] = '{1023, 2'b01, 8'hFC};
    spots[4] = '{1024, 2'b00, 8'h00};
    spots[5] = '{1039, 2'b00, 8'h00};
    spots[6] = '{1040, 2'b10, 8'h00};
    spots[7] = '{2047, 2'b10, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_con_a", 0, 32'(con_a), 32'd0);
    chk("rst_seg_a", 0, 32'(seg_a), 32'd0);
    chk("rst_con_c", 0, 32'(con_c), 32'd0);
    chk("rst_ack_c", 0, 32'(if_c.upd_ack), 32'd0);

    // First frame: fixed scan pattern, request raised at cycle 100.
    release_ab();
    req_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (spots[k].cyc > 100 && !req_done) begin
        goto(99);
        @(posedge clk);
        #1;
        req = 1'b1;
        data = 8'h47;
        req_done = 1'b1;
      end
      goto(spots[k].cyc);
      chk("spot_con", spots[k].cyc, 32'(con_a), 32'(spots[k].con));
      chk("spot_seg", spots[k].cyc, 32'(seg_a), 32'(spots[k].seg));
    end
    wait_ack(ac);
    chk("first_ack_cycle", 0, ac, F);
    @(posedge clk);
    #1;
    req = 1'b0;
    goto(ac + 500);
    chk("h47_d0", ac, 32'(seg_a), 32'hE0);
    goto(ac + 1524);
    chk("h47_d1", ac, 32'(seg_a), 32'h66);

    // Table of display values, LZ on (a) and off (b).
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 600)) @(posedge clk);
      @(posedge clk);
      #1;
      req = 1'b1;
      data = vecs[k].d;
      s = n;
      wait_ack(ac);
      chk("vec_ack", k, ac, (s / F + 1) * F);
      @(posedge clk);
      #1;
      req = 1'b0;
      goto(ac + 500);
      chk("vec_con0", k, 32'(con_a), 32'd1);
      chk("vec_a0", k, 32'(seg_a), 32'(vecs[k].a0));
      chk("vec_b0", k, 32'(seg_b), 32'(vecs[k].b0));
      goto(ac + 1524);
      chk("vec_con1", k, 32'(con_a), 32'd2);
      chk("vec_a1", k, 32'(seg_a), 32'(vecs[k].a1));
      chk("vec_b1", k, 32'(seg_b), 32'(vecs[k].b1));
    end

    // Random updates; some requests are held across two frame ends.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 1500)) @(posedge clk);
      @(posedge clk);
      #1;
      req = 1'b1;
      data = 8'($urandom);
      wait_ack(ac);
      r = int'($urandom_range(0, 1));
      if (r == 1) begin
        @(posedge clk);
        #1;
        data = 8'($urandom);
        wait_ack(ac2);
        chk("hold_ack_gap", k, ac2 - ac, F);
      end
      @(posedge clk);
      #1;
      req = 1'b0;
    end

    // Reset in the middle of digit 1 with a request pending.
    t = (n / F + 1) * F + 1500;
    goto(t - 1);
    @(posedge clk);
    #1;
    req = 1'b1;
    data = 8'h33;
    chk("pre_rst_con", t, 32'(con_a), 32'd2);
    #2;
    res = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("mid_rst_con_a", t, 32'(con_a), 32'd0);
    chk("mid_rst_seg_a", t, 32'(seg_a), 32'd0);
    chk("mid_rst_tick_a", t, 32'(tick_a), 32'd0);
    chk("mid_rst_con_b", t, 32'(con_b), 32'd0);
    chk("mid_rst_ack_b", t, 32'(if_b.upd_ack), 32'd0);
    repeat (2) @(posedge clk);
    release_ab();
    wait_ack(ac);
    chk("rst_ack_cycle", 0, ac, F);
    @(posedge clk);
    #1;
    req = 1'b0;
    goto(F + 20);
    chk("rst_new_d0", 0, 32'(seg_a), 32'hF2);

    // Three digits, four-cycle slots, no blank interval.
    @(negedge clk);
    #1;
    res_c = 1'b0;
    act_c = '0;
    prev_rc = 1'b0;
    prev_dc = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      et = 1'b0;
      ea = 1'b0;
      if (k > 0 && k % FC == 0) begin
        et = 1'b1;
        ea = prev_rc;
        if (prev_rc) act_c = {20'd0, prev_dc};
      end
      ci = (k % FC) / SDC;
      chk("c_con", k, 32'(con_c), 32'd1 << ci);
      chk("c_seg", k, 32'(seg_c), 32'(model_seg(act_c, ci, 1'b1)));
      chk("c_tick", k, 32'(tick_c), 32'(et));
      chk("c_ack", k, 32'(if_c.upd_ack), 32'(ea));
      if (k == 5) begin
        req_c = 1'b1;
        data_c = 12'h907;
      end
      if (k == 12 || k == 36) req_c = 1'b0;
      if (k == 30) begin
        req_c = 1'b1;
        data_c = 12'h00A;
      end
      prev_rc = req_c;
      prev_dc = data_c;
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
